// File: rtl/updown_preload_counter.sv
// Up/down counter with synchronous parallel preload and count enable.
// Arithmetic wraps modulo 2^WIDTH; count is taken straight from the state register.
module updown_preload_counter #(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             up_down,
  input  logic             preload,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: preload beats counting; counting only when enabled.
  always_comb begin
    count_d = count_q;
    if (preload) begin
      count_d = data;
    end else if (enable) begin
      if (up_down) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_updown_preload_counter.sv
// Self-checking bench for updown_preload_counter: directed scenarios plus
// randomized traffic compared against an arithmetic reference model.
module tb_updown_preload_counter;

  localparam int unsigned W   = 8;
  localparam int unsigned MOD = 1 << W;
  localparam logic [W-1:0] RV = '0;

  logic         clk = 1'b0;
  logic         resetn;
  logic         up_down;
  logic         preload;
  logic         enable;
  logic [W-1:0] data;
  logic [W-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned exp_cnt;

  updown_preload_counter #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .up_down (up_down),
    .preload (preload),
    .data    (data),
    .enable  (enable),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: count=%0d expected=%0d at %0t", tag, obs, expv, $time);
  endtask

  // Reference behaviour of one rising edge, then compare shortly after it.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!resetn)       exp_cnt = RV;
    else if (preload)  exp_cnt = data;
    else if (enable)   exp_cnt = up_down ? (exp_cnt + 1) % MOD : (exp_cnt + MOD - 1) % MOD;
    #1;
    check(tag, count, W'(exp_cnt));
  endtask

  // Assert reset between edges and confirm it acts without a clock.
  task automatic async_reset_pulse(input string tag);
    #2 resetn = 1'b0;
    #1 exp_cnt = RV;
    check(tag, count, W'(exp_cnt));
    #1 resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; up_down = 1'b1; preload = 1'b0; enable = 1'b1; data = '0;
    exp_cnt = RV;
    #1 check("reset_initial", count, RV);

    // Reset held while direction toggles.
    for (int i = 0; i < 75; i++) begin
      up_down = (i < 25 || i >= 50);
      tick("reset_hold");
    end

    // Release and count up through the wrap.
    @(negedge clk);
    resetn = 1'b1; up_down = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick("up_count");
      if (i == 13)  check("up_13", count, 8'd13);
      if (i == 255) check("up_255", count, 8'd255);
      if (i == 256) check("up_wrap", count, 8'd0);
    end

    // Preload held for 19 edges, then resume counting from the loaded value.
    preload = 1'b1; data = 8'd12;
    for (int i = 0; i < 19; i++) begin
      tick("preload_hold");
      check("preload_12", count, 8'd12);
    end
    preload = 1'b0; data = 8'd9; up_down = 1'b1;
    tick("after_preload");
    check("after_preload_13", count, 8'd13);
    tick("after_preload");
    check("after_preload_14", count, 8'd14);

    // Down count through zero.
    preload = 1'b1; data = 8'd2;
    tick("preload_2");
    preload = 1'b0; up_down = 1'b0;
    tick("down"); check("down_1", count, 8'd1);
    tick("down"); check("down_0", count, 8'd0);
    tick("down"); check("down_255", count, 8'd255);
    tick("down"); check("down_254", count, 8'd254);

    // Direction change with no dead cycle: 10 -> 11 -> 10.
    preload = 1'b1; data = 8'd10;
    tick("preload_10");
    preload = 1'b0; up_down = 1'b1;
    tick("dir_up"); check("dir_11", count, 8'd11);
    up_down = 1'b0;
    tick("dir_down"); check("dir_10", count, 8'd10);

    // Enable low freezes; preload still wins.
    enable = 1'b0; up_down = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick("enable_hold");
      check("frozen_10", count, 8'd10);
    end
    preload = 1'b1; data = 8'hA5;
    tick("preload_a5"); check("preload_a5", count, 8'hA5);

    // Async reset mid-operation, then restart from zero.
    data = 8'h40;
    tick("preload_40"); check("preload_40", count, 8'h40);
    preload = 1'b0; enable = 1'b1; up_down = 1'b1;
    #2 resetn = 1'b0;
    #1 exp_cnt = RV;
    check("async_clear", count, 8'd0);
    tick("reset_held_edge");
    @(negedge clk) resetn = 1'b1;
    tick("restart"); check("restart_1", count, 8'd1);
    tick("restart"); check("restart_2", count, 8'd2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      preload = ($urandom_range(7) == 0);
      enable  = ($urandom_range(3) != 0);
      up_down = 1'($urandom_range(1));
      data    = W'($urandom);
      tick("random");
      if ($urandom_range(39) == 0) async_reset_pulse("random_async_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
